// File: rtl/hamming_serializer.sv
// rtl/hamming_serializer.sv - Serializes a 16-bit Hamming package as start + data (+ optional stop) bits.
// Optional stop bit enabled by defining HAMMING_TX_STOP_BIT_EN.
module hamming_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] package_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

`ifdef HAMMING_TX_STOP_BIT_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA} state_t;
`endif

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_shift, w_shift_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_bit_idx, w_bit_idx_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_done, w_done_nxt;
  logic        w_accept;
  logic        w_bit_end;

  assign ready_o   = (r_state == S_IDLE) && !rst_i;
  assign busy_o    = (r_state != S_IDLE);
  assign tx_o      = r_tx;
  assign done_o    = r_done;
  assign w_accept  = valid_i && ready_o;
  assign w_bit_end = (r_cnt == LAST_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // The shifter's MSB is always the next data bit to put on the line.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;
    w_cnt_nxt     = w_bit_end ? 16'd0 : r_cnt + 16'd1;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (w_accept) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = package_i;
          w_bit_idx_nxt = 4'd15;
          w_tx_nxt      = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 4'd15;
          w_tx_nxt      = r_shift[15];
          w_shift_nxt   = {r_shift[14:0], 1'b0};
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 4'd0) begin
            w_tx_nxt = 1'b1;
`ifdef HAMMING_TX_STOP_BIT_EN
            w_state_nxt = S_STOP;
`else
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx - 4'd1;
            w_tx_nxt      = r_shift[15];
            w_shift_nxt   = {r_shift[14:0], 1'b0};
          end
        end
      end
`ifdef HAMMING_TX_STOP_BIT_EN
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_hamming_serializer.sv
// tb/tb_hamming_serializer.sv - Self-checking bench for hamming_serializer (CLKS_PER_BIT 4 and 1).
module tb_hamming_serializer;

`ifdef HAMMING_TX_STOP_BIT_EN
  localparam int NBITS = 18;
`else
  localparam int NBITS = 17;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b1, valid4 = 1'b0;
  logic [15:0] pkg4 = '0;
  logic        ready4, tx4, busy4, done4;
  logic        rst1 = 1'b1, valid1 = 1'b0;
  logic [15:0] pkg1 = '0;
  logic        ready1, tx1, busy1, done1;

  int n_checks = 0;
  int n_pass   = 0;

  hamming_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .package_i(pkg4), .valid_i(valid4),
    .ready_o(ready4), .tx_o(tx4), .busy_o(busy4), .done_o(done4)
  );

  hamming_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .package_i(pkg1), .valid_i(valid1),
    .ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .done_o(done1)
  );

  // Line level per cycle from the first start-bit cycle: bit period b is start (0), package MSB first, then stop (1).
  function automatic logic [71:0] model_wave(input logic [15:0] pkg, input int c);
    logic [71:0] w;
    logic        bv;
    int          n;
    w = '1;
    n = 0;
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)       bv = 1'b0;
      else if (b <= 16) bv = pkg[16-b];
      else              bv = 1'b1;
      for (int k = 0; k < c; k++) begin
        w[n] = bv;
        n++;
      end
    end
    return w;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (tx4 !== 1'b1)    $display("FAIL reset_tx4 got %b want 1", tx4); else n_pass++;
    n_checks++; if (ready4 !== 1'b0) $display("FAIL reset_ready4 got %b want 0", ready4); else n_pass++;
    n_checks++; if (busy4 !== 1'b0)  $display("FAIL reset_busy4 got %b want 0", busy4); else n_pass++;
    n_checks++; if (done4 !== 1'b0)  $display("FAIL reset_done4 got %b want 0", done4); else n_pass++;
    n_checks++; if (ready1 !== 1'b0) $display("FAIL reset_ready1 got %b want 0", ready1); else n_pass++;
    n_checks++; if (tx1 !== 1'b1)    $display("FAIL reset_tx1 got %b want 1", tx1); else n_pass++;
    rst4 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready4 !== 1'b1) $display("FAIL release_ready4 got %b want 1", ready4); else n_pass++;
    n_checks++; if (ready1 !== 1'b1) $display("FAIL release_ready1 got %b want 1", ready1); else n_pass++;
  endtask

  task automatic frame4(input logic [15:0] pkg, input bit noise, input string tag);
    logic [71:0] obs, exp_w;
    int done_at, done_cnt, busy_gaps, len;
    len   = NBITS * 4;
    exp_w = model_wave(pkg, 4);
    @(negedge clk);
    n_checks++; if (ready4 !== 1'b1) $display("FAIL %s_ready got %b want 1", tag, ready4); else n_pass++;
    pkg4   = pkg;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    pkg4   = 16'($urandom);
    obs = '1; done_at = -1; done_cnt = 0; busy_gaps = 0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) @(negedge clk);
      if (k < len) begin
        obs[k] = tx4;
        if (busy4 !== 1'b1) busy_gaps++;
      end
      if (done4 === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      valid4 = noise && (k == 20 || k == 21);
      if (valid4) pkg4 = 16'hFFFF;
    end
    n_checks++; if (obs !== exp_w) $display("FAIL %s_wave got %h want %h", tag, obs, exp_w); else n_pass++;
    n_checks++; if (done_at != len) $display("FAIL %s_done_at got %0d want %0d", tag, done_at, len); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL %s_done_cnt got %0d want 1", tag, done_cnt); else n_pass++;
    n_checks++; if (busy_gaps != 0) $display("FAIL %s_busy_gaps got %0d want 0", tag, busy_gaps); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done4 !== 1'b0 || tx4 !== 1'b1 || busy4 !== 1'b0)
      $display("FAIL %s_after got done=%b tx=%b busy=%b want 0 1 0", tag, done4, tx4, busy4);
    else n_pass++;
  endtask

  task automatic test_vector();
    frame4(16'h1EEE, 1'b0, "vec_1EEE");
  endtask

  task automatic test_busy_ignore();
    frame4(16'h1EEE, 1'b1, "busy_ignore");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) frame4(16'($urandom), bit'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_back_to_back();
    logic [63:0] obs, exp_w, obs_done, exp_done, obs_busy, exp_busy;
    logic [71:0] w0, w1;
    int total;
    total = 2 * NBITS + 2;
    w0 = model_wave(16'h0000, 1);
    w1 = model_wave(16'hFFFF, 1);
    exp_w = '0; exp_done = '0; exp_busy = '0;
    for (int k = 0; k < total; k++) begin
      if (k < NBITS)           exp_w[k] = w0[k];
      else if (k == NBITS)     exp_w[k] = 1'b1;
      else if (k <= 2 * NBITS) exp_w[k] = w1[k - NBITS - 1];
      else                     exp_w[k] = 1'b1;
      exp_done[k] = (k == NBITS) || (k == 2 * NBITS + 1);
      exp_busy[k] = (k != NBITS) && (k <= 2 * NBITS);
    end
    @(negedge clk);
    n_checks++; if (ready1 !== 1'b1) $display("FAIL b2b_ready got %b want 1", ready1); else n_pass++;
    pkg1   = 16'h0000;
    valid1 = 1'b1;
    @(negedge clk);
    pkg1 = 16'hFFFF;
    obs = '0; obs_done = '0; obs_busy = '0;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk);
      obs[k]      = tx1;
      obs_done[k] = done1;
      obs_busy[k] = busy1;
      if (k == NBITS + 3) valid1 = 1'b0;
    end
    n_checks++; if (obs !== exp_w) $display("FAIL b2b_wave got %h want %h", obs, exp_w); else n_pass++;
    n_checks++; if (obs_done !== exp_done) $display("FAIL b2b_done got %h want %h", obs_done, exp_done); else n_pass++;
    n_checks++; if (obs_busy !== exp_busy) $display("FAIL b2b_busy got %h want %h", obs_busy, exp_busy); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int dones, lows;
    @(negedge clk);
    pkg4   = 16'h1EEE;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    repeat (37) @(negedge clk);
    rst4 = 1'b1;
    #1;
    n_checks++; if (tx4 !== 1'b1)    $display("FAIL abort_tx got %b want 1", tx4); else n_pass++;
    n_checks++; if (busy4 !== 1'b0)  $display("FAIL abort_busy got %b want 0", busy4); else n_pass++;
    n_checks++; if (ready4 !== 1'b0) $display("FAIL abort_ready got %b want 0", ready4); else n_pass++;
    @(negedge clk);
    rst4 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready4 !== 1'b1) $display("FAIL abort_release_ready got %b want 1", ready4); else n_pass++;
    dones = 0; lows = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done4 !== 1'b0) dones++;
      if (tx4 !== 1'b1) lows++;
    end
    n_checks++; if (dones != 0) $display("FAIL abort_no_done got %0d want 0", dones); else n_pass++;
    n_checks++; if (lows != 0) $display("FAIL abort_idle_line got %0d low cycles want 0", lows); else n_pass++;
    frame4(16'h1EEE, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_vector();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_serializer.md
HAMMING_SERIALIZER -- requirements
Module: hamming_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4; clock cycles each serial bit is held on the line; legal range 1..65535.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 package_i  input  16  encoded Hamming package from the coder stage; bit 15 transmitted first.
REQ-005 valid_i  input  1  package_i holds a package to send.
REQ-006 ready_o  output  1  block accepts a package this cycle.
REQ-007 tx_o  output  1  serial line, registered, idle level 1.
REQ-008 busy_o  output  1  frame in progress (any state other than IDLE).
REQ-009 done_o  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 FSM states IDLE, START, DATA, STOP; STOP exists only with HAMMING_TX_STOP_BIT_EN defined.
REQ-011 ready_o SHALL be 1 exactly when state is IDLE and rst_i is low.
REQ-012 Transfer occurs on a rising edge with valid_i=1 and ready_o=1; package_i is captured into a 16-bit shift register at that edge, and later changes to package_i do not affect the frame.
REQ-013 On transfer, state -> START and tx_o = 0 from the next cycle (one-cycle latency from accepting edge to start-bit edge).
REQ-014 Each bit SHALL be held on tx_o for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that reloads at every bit boundary.
REQ-015 START -> DATA after CLKS_PER_BIT cycles; DATA drives package bits 15 down to 0, one per bit period, using a 4-bit bit index.
REQ-016 After bit 0 completes: -> STOP (tx_o = 1 for CLKS_PER_BIT cycles) when the macro is defined, otherwise -> IDLE directly.
REQ-017 Frame length SHALL be 17*CLKS_PER_BIT cycles without the stop bit and 18*CLKS_PER_BIT cycles with it, measured from the first start-bit cycle.
REQ-018 done_o SHALL be 1 for exactly the first IDLE cycle after a completed frame; otherwise 0.
REQ-019 Back-to-back: if valid_i=1 during that first IDLE cycle, the transfer occurs at its end, giving exactly one idle-level (1) cycle between frames.
REQ-020 valid_i while busy_o=1 SHALL be ignored, with no capture or state change.
REQ-021 tx_o SHALL be 1 in IDLE and STOP; it never glitches between bit boundaries.
REQ-022 CLKS_PER_BIT=1 SHALL work: one cycle per bit, no skipped or repeated bits.

Reset
REQ-023 While rst_i=1: state IDLE, tx_o=1, ready_o=0, busy_o=0, done_o=0, counters and shift register cleared.
REQ-024 rst_i asserted mid-frame SHALL abort the frame immediately (asynchronous); no done_o pulse follows; ready_o=1 on the first edge after rst_i deasserts.

Configuration
REQ-025 Macro HAMMING_TX_STOP_BIT_EN defined: frame = start + 16 data + one stop bit (18 bit periods).
REQ-026 Macro HAMMING_TX_STOP_BIT_EN undefined: no STOP state; frame = start + 16 data (17 bit periods); all other behaviour identical.

Verification
REQ-027 CLKS_PER_BIT=4, macro defined, package_i=16'h1EEE (coder output for data 8'hFF), one valid pulse -> tx_o per bit period: 0, then 0001111011101110, then 1; done_o pulses once, 72 cycles after the start bit begins.
REQ-028 Same stimulus with macro undefined -> identical start and data bits with no stop period; done_o at cycle 68.
REQ-029 CLKS_PER_BIT=1, valid_i held 1, packages 16'h0000 then 16'hFFFF -> two frames separated by exactly one idle cycle at tx_o=1; package_i changes mid-frame are ignored.
REQ-030 rst_i pulsed high during data bit 7 of 16'h1EEE -> tx_o=1 immediately, no done_o, next frame accepted and sent correctly.
REQ-031 valid_i pulsed with package_i=16'hFFFF while busy_o=1 -> current frame bits unchanged, second package not sent.
